// File: rtl/dict_pkg.sv
// -----------------------------------------------------------------------------
// dict_pkg
// Shared definitions for the dictionary write side (dict_writer) and the
// lookup side (find_index):
//   dict_state_t     - writer FSM states
//   DEF_ENTRIES      - default number of dictionary entries
//   DEF_KEY_WIDTH    - default bits per name character
//   DEF_KEY_LENGTH   - default maximum characters per name
//   len_bits()       - width of a counter that must hold 0..n inclusive
// -----------------------------------------------------------------------------
package dict_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2,
        COMMIT  = 2'd3
    } dict_state_t;

    localparam int DEF_ENTRIES    = 2;
    localparam int DEF_KEY_WIDTH  = 8;
    localparam int DEF_KEY_LENGTH = 1;

    // Bits needed to count from 0 up to and including n (never less than 1).
    function automatic int len_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_assembler.sv
// -----------------------------------------------------------------------------
// key_assembler
// Packs name characters into a zero-padded key buffer, one character per
// accepted handshake. Character j of a name lands at buffer position j.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   flush     in   synchronous clear of buffer and length (new name / clear)
//   accept    in   a character is being consumed this cycle
//   char_in   in   KEY_WIDTH  character being consumed
//   key_next  out  buffer as it will look with char_in merged at the current
//                  length position (used directly when the final character
//                  commits in the same edge)
//   at_limit  out  KEY_LENGTH characters already held; the next accepted
//                  character overflows the name
// -----------------------------------------------------------------------------
module key_assembler
    import dict_pkg::*;
#(
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int KEY_LENGTH = DEF_KEY_LENGTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 accept,
    input  logic [KEY_WIDTH-1:0]                 char_in,
    output logic [KEY_LENGTH-1:0][KEY_WIDTH-1:0] key_next,
    output logic                                 at_limit
);

    localparam int LEN_BITS = len_bits(KEY_LENGTH);

    logic [KEY_LENGTH-1:0][KEY_WIDTH-1:0] buffer;
    logic [LEN_BITS-1:0]                  len;

    always_comb begin
        at_limit = (len == LEN_BITS'(KEY_LENGTH));
        key_next = buffer;
        // When len == KEY_LENGTH no position matches, so an overflowing
        // character never disturbs the stored prefix.
        for (int j = 0; j < KEY_LENGTH; j++) begin
            if (len == LEN_BITS'(j)) begin
                key_next[j] = char_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer <= '0;
            len    <= '0;
        end else if (flush) begin
            buffer <= '0;
            len    <= '0;
        end else if (accept && !at_limit) begin
            buffer <= key_next;
            len    <= len + 1'b1;
        end
    end

endmodule

// File: rtl/dict_writer.sv
// -----------------------------------------------------------------------------
// dict_writer
// Write side of the dictionary: collects a name one character per handshake
// and appends it as a zero-padded key to the next free entry of the key table
// that find_index searches.
// Ports:
//   i_clk       in   clock, all state on rising edge
//   i_reset     in   asynchronous active-high reset
//   i_valid     in   i_char valid
//   i_char      in   KEY_WIDTH name character
//   i_last      in   i_char is the final character of the name
//   o_ready     out  character accepted when i_valid && o_ready at the edge
//   i_clear     in   synchronous: forget all entries (overrides everything)
//   o_keys      out  key table [ENTRIES][KEY_LENGTH][KEY_WIDTH], same layout
//                    as find_index i_keys
//   o_count     out  number of valid entries
//   o_index     out  entry written by the last successful commit
//   o_done      out  one-cycle pulse, commit succeeded
//   o_full_err  out  one-cycle pulse, name dropped, table full
//   o_len_err   out  one-cycle pulse, name dropped, longer than KEY_LENGTH
// -----------------------------------------------------------------------------
module dict_writer
    import dict_pkg::*;
#(
    parameter int ENTRIES    = DEF_ENTRIES,
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int KEY_LENGTH = DEF_KEY_LENGTH,
    localparam int INDEX_BITS = $clog2(ENTRIES),
    localparam int COUNT_BITS = $clog2(ENTRIES + 1)
) (
    input  logic                                              i_clk,
    input  logic                                              i_reset,
    input  logic                                              i_valid,
    input  logic [KEY_WIDTH-1:0]                              i_char,
    input  logic                                              i_last,
    output logic                                              o_ready,
    input  logic                                              i_clear,
    output logic [ENTRIES-1:0][KEY_LENGTH-1:0][KEY_WIDTH-1:0] o_keys,
    output logic [COUNT_BITS-1:0]                             o_count,
    output logic [INDEX_BITS-1:0]                             o_index,
    output logic                                              o_done,
    output logic                                              o_full_err,
    output logic                                              o_len_err
);

    localparam logic [COUNT_BITS-1:0] FULL_COUNT = COUNT_BITS'(ENTRIES);

    dict_state_t                          state;
    logic                                 accept;
    logic                                 flush;
    logic                                 at_limit;
    logic [KEY_LENGTH-1:0][KEY_WIDTH-1:0] key_next;
    logic                                 end_name;
    logic                                 len_bad;
    logic                                 table_full;

    // o_ready is a register that is low only in COMMIT, so accept never
    // fires while a commit is being presented.
    always_comb begin
        accept     = i_valid && o_ready;
        end_name   = accept && i_last;
        // The name is too long if we are already dropping characters, or if
        // this final character is itself the one that overflows.
        len_bad    = (state == DISCARD) || ((state == COLLECT) && at_limit);
        table_full = (o_count == FULL_COUNT);
        // The buffer is emptied while COMMIT is shown so IDLE starts clean.
        flush      = i_clear || (state == COMMIT);
    end

    key_assembler #(
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_LENGTH(KEY_LENGTH)
    ) u_key_assembler (
        .clk     (i_clk),
        .rst     (i_reset),
        .flush   (flush),
        .accept  (accept),
        .char_in (i_char),
        .key_next(key_next),
        .at_limit(at_limit)
    );

    // The table update and the result pulse are registered on the edge that
    // accepts the final character; the FSM then sits in COMMIT for exactly
    // that visible cycle with o_ready low.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            o_ready    <= 1'b0;
            o_keys     <= '0;
            o_count    <= '0;
            o_index    <= '0;
            o_done     <= 1'b0;
            o_full_err <= 1'b0;
            o_len_err  <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_full_err <= 1'b0;
            o_len_err  <= 1'b0;
            if (i_clear) begin
                state   <= IDLE;
                o_ready <= 1'b1;
                o_keys  <= '0;
                o_count <= '0;
                o_index <= '0;
            end else if (end_name) begin
                state   <= COMMIT;
                o_ready <= 1'b0;
                if (len_bad) begin
                    o_len_err <= 1'b1;
                end else if (table_full) begin
                    o_full_err <= 1'b1;
                end else begin
                    o_keys[o_count[INDEX_BITS-1:0]] <= key_next;
                    o_index <= o_count[INDEX_BITS-1:0];
                    o_count <= o_count + 1'b1;
                    o_done  <= 1'b1;
                end
            end else begin
                o_ready <= 1'b1;
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (accept && at_limit) begin
                            state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        state <= DISCARD;
                    end
                    COMMIT: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dict_writer.sv
module tb_dict_writer;

    localparam int ENTRIES    = 4;
    localparam int KEY_WIDTH  = 8;
    localparam int KEY_LENGTH = 3;

    logic                            i_clk = 1'b0;
    logic                            i_reset;
    logic                            i_valid;
    logic [7:0]                      i_char;
    logic                            i_last;
    logic                            o_ready;
    logic                            i_clear;
    logic [3:0][2:0][7:0]            o_keys;
    logic [2:0]                      o_count;
    logic [1:0]                      o_index;
    logic                            o_done;
    logic                            o_full_err;
    logic                            o_len_err;

    int checks = 0;
    int errors = 0;

    logic [3:0][2:0][7:0] exp_keys;
    int                   stall;

    dict_writer #(
        .ENTRIES   (ENTRIES),
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_LENGTH(KEY_LENGTH)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_char    (i_char),
        .i_last    (i_last),
        .o_ready   (o_ready),
        .i_clear   (i_clear),
        .o_keys    (o_keys),
        .o_count   (o_count),
        .o_index   (o_index),
        .o_done    (o_done),
        .o_full_err(o_full_err),
        .o_len_err (o_len_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0][7:0] mk(input string s);
        logic [2:0][7:0] k;
        k = '0;
        for (int i = 0; i < s.len() && i < 3; i++) k[i] = s[i];
        return k;
    endfunction

    // Reference lookup: lowest index among valid entries whose key matches.
    function automatic int lookup(input logic [3:0][2:0][7:0] tbl, input logic [2:0] cnt,
                                  input logic [2:0][7:0] key);
        for (int e = 0; e < 4; e++) begin
            if (e < int'(cnt) && tbl[e] == key) return e;
        end
        return -1;
    endfunction

    // Presents one character from a falling edge, waits (bounded) for o_ready,
    // and returns #1 after the accepting rising edge.
    task automatic send(input logic [7:0] c, input logic last, input int gap, output int waited);
        waited  = 0;
        i_valid = 1'b0;
        repeat (gap) @(negedge i_clk);
        @(negedge i_clk);
        while (!o_ready && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        check("ready_wait", 128'(waited < 20), 128'(1));
        i_valid = 1'b1;
        i_char  = c;
        i_last  = last;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_char  = 8'h00;
    endtask

    task automatic send_name(input string s, input int maxgap, output int stl);
        int w;
        int g;
        stl = 0;
        for (int i = 0; i < s.len(); i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            send(s[i], (i == s.len() - 1), g, w);
            if (i > 0) stl += w;
        end
    endtask

    initial begin
        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_char   = 8'h00;
        i_last   = 1'b0;
        i_clear  = 1'b0;
        exp_keys = '0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 128'(o_ready), 128'(0));
        check("rst_count", 128'(o_count), 128'(0));
        check("rst_index", 128'(o_index), 128'(0));
        check("rst_keys", 128'(o_keys), 128'(0));
        check("rst_pulses", 128'({o_done, o_full_err, o_len_err}), 128'(0));
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        check("ready_after_rst", 128'(o_ready), 128'(1));

        // "DUP" -> entry 0
        send_name("DUP", 0, stall);
        exp_keys[0] = {8'h50, 8'h55, 8'h44};
        check("dup_done", 128'(o_done), 128'(1));
        check("dup_index", 128'(o_index), 128'(0));
        check("dup_count", 128'(o_count), 128'(1));
        check("dup_key0", 128'(o_keys[0]), 128'({8'h50, 8'h55, 8'h44}));
        check("dup_ready_low", 128'(o_ready), 128'(0));
        @(posedge i_clk);
        #1;
        check("dup_done_drop", 128'(o_done), 128'(0));
        check("dup_ready_back", 128'(o_ready), 128'(1));

        // "+" -> entry 1, ready low for exactly one cycle
        send_name("+", 0, stall);
        exp_keys[1] = {8'h00, 8'h00, 8'h2B};
        check("plus_done", 128'(o_done), 128'(1));
        check("plus_key1", 128'(o_keys[1]), 128'({8'h00, 8'h00, 8'h2B}));
        check("plus_count", 128'(o_count), 128'(2));
        check("plus_index", 128'(o_index), 128'(1));
        check("plus_ready_low", 128'(o_ready), 128'(0));
        @(posedge i_clk);
        #1;
        check("plus_ready_back", 128'(o_ready), 128'(1));

        // "SWAPX" too long: len error, nothing written, no stalls
        send_name("SWAPX", 0, stall);
        check("swapx_len_err", 128'(o_len_err), 128'(1));
        check("swapx_done", 128'(o_done), 128'(0));
        check("swapx_count", 128'(o_count), 128'(2));
        check("swapx_keys", 128'(o_keys), 128'(exp_keys));
        check("swapx_stall", 128'(stall), 128'(0));
        @(posedge i_clk);
        #1;
        check("swapx_len_err_drop", 128'(o_len_err), 128'(0));

        // "ABCD": the overflowing character is itself the last one
        send_name("ABCD", 0, stall);
        check("abcd_len_err", 128'(o_len_err), 128'(1));
        check("abcd_count", 128'(o_count), 128'(2));

        // Fill to 4 entries, then a fifth name overflows the table
        send_name("CC", 0, stall);
        exp_keys[2] = {8'h00, 8'h43, 8'h43};
        check("cc_index", 128'(o_index), 128'(2));
        send_name("E", 0, stall);
        exp_keys[3] = {8'h00, 8'h00, 8'h45};
        check("e_index", 128'(o_index), 128'(3));
        check("e_count", 128'(o_count), 128'(4));
        send_name("A", 0, stall);
        check("full_err", 128'(o_full_err), 128'(1));
        check("full_done", 128'(o_done), 128'(0));
        check("full_count", 128'(o_count), 128'(4));
        check("full_keys", 128'(o_keys), 128'(exp_keys));
        check("full_index", 128'(o_index), 128'(3));

        // Clear in the middle of a name, with a character presented alongside
        send(8'h51, 1'b0, 0, stall);
        send(8'h52, 1'b0, 0, stall);
        @(negedge i_clk);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_char  = 8'h5A;
        i_last  = 1'b1;
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        exp_keys = '0;
        check("clr_count", 128'(o_count), 128'(0));
        check("clr_keys", 128'(o_keys), 128'(0));
        check("clr_index", 128'(o_index), 128'(0));
        check("clr_pulses", 128'({o_done, o_full_err, o_len_err}), 128'(0));
        check("clr_ready", 128'(o_ready), 128'(1));
        send_name("HI", 0, stall);
        check("hi_done", 128'(o_done), 128'(1));
        check("hi_index", 128'(o_index), 128'(0));
        check("hi_key0", 128'(o_keys[0]), 128'({8'h00, 8'h49, 8'h48}));
        check("hi_count", 128'(o_count), 128'(1));

        // Reset while in COMMIT
        send_name("K", 0, stall);
        check("k_ready_low", 128'(o_ready), 128'(0));
        i_reset = 1'b1;
        #1;
        check("rc_done", 128'(o_done), 128'(0));
        check("rc_count", 128'(o_count), 128'(0));
        check("rc_keys", 128'(o_keys), 128'(0));
        check("rc_index", 128'(o_index), 128'(0));
        check("rc_ready", 128'(o_ready), 128'(0));
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        check("rc_ready_back", 128'(o_ready), 128'(1));
        check("rc_done_after", 128'(o_done), 128'(0));

        // Gapped stream with a duplicate; lookup finds the lowest match
        send_name("AB", 3, stall);
        check("g_ab_index", 128'(o_index), 128'(0));
        send_name("Z", 3, stall);
        check("g_z_index", 128'(o_index), 128'(1));
        send_name("XY", 3, stall);
        check("g_xy_index", 128'(o_index), 128'(2));
        send_name("XY", 3, stall);
        check("g_xy2_index", 128'(o_index), 128'(3));
        check("g_xy2_done", 128'(o_done), 128'(1));
        @(posedge i_clk);
        #1;
        check("look_ab", 128'(lookup(o_keys, o_count, mk("AB"))), 128'(0));
        check("look_z", 128'(lookup(o_keys, o_count, mk("Z"))), 128'(1));
        check("look_xy", 128'(lookup(o_keys, o_count, mk("XY"))), 128'(2));
        check("look_missing", 128'(lookup(o_keys, o_count, mk("Q"))), 128'(-1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dict_writer.md
# dict_writer

Appends new dictionary entries (word names) to the key table consumed by `find_index`. Name characters arrive one per handshake from the parser and are packed into a zero-padded key. On the final character the key is committed to the next free entry. The block owns the key storage and drives it out in exactly the layout the lookup expects. It is the write side of the dictionary, while `find_index` is the search side.

## Interface
- `ENTRIES`, 2, number of dictionary entries
- `KEY_WIDTH`, 8, bits per name character
- `KEY_LENGTH`, 1, maximum characters per name
- localparam `INDEX_BITS` = $clog2(ENTRIES); `COUNT_BITS` = $clog2(ENTRIES+1)

Ports:
- `i_clk`  in  1  clock, all state on rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_valid`  in  1  `i_char` valid
- `i_char`  in  KEY_WIDTH  name character
- `i_last`  in  1  qualifies `i_char` as final character of the name
- `o_ready`  out  1  character accepted when `i_valid && o_ready` at clock edge
- `i_clear`  in  1  forget all entries
- `o_keys`  out  [KEY_WIDTH-1:0] x [ENTRIES-1:0][KEY_LENGTH-1:0]  key table, same layout as `find_index` `i_keys`
- `o_count`  out  COUNT_BITS  number of valid entries
- `o_index`  out  INDEX_BITS  entry written by the last successful commit
- `o_done`  out  1  one-cycle pulse, commit succeeded
- `o_full_err`  out  1  one-cycle pulse, name dropped because the table is full
- `o_len_err`  out  1  one-cycle pulse, name dropped because it exceeds KEY_LENGTH

## Operation
- The FSM has four states: IDLE, COLLECT, DISCARD, COMMIT. `o_ready` = 1 in IDLE, COLLECT and DISCARD, and 0 in COMMIT.
- A character accepted as the j-th of its name (j from 0) is stored at buffer position j. Positions not written stay 0. The buffer clears on entry to IDLE.
- State transitions:
  - IDLE: an accepted character goes to COLLECT, or to COMMIT if `i_last`.
  - COLLECT: each accepted character increments the length counter. `i_last` goes to COMMIT. An accepted character when length == KEY_LENGTH goes to DISCARD and is dropped. If that dropped character carries `i_last`, go straight to the length-error commit.
  - DISCARD: accept and drop characters until `i_last`, then go to COMMIT with the length-error flag set.
  - COMMIT: one cycle, then IDLE.
    - If the length-error flag is set: pulse `o_len_err`, no write.
    - Else if `o_count` == ENTRIES: pulse `o_full_err`, no write.
    - Else: write the buffer to `o_keys[o_count]`, set `o_index` = `o_count`, increment `o_count`, pulse `o_done`.
- Names always have length 1 or more, because `i_last` accompanies a character.
- Duplicate names are not checked and are stored again. Lookup returns the lowest matching index.
- `i_clear` is synchronous and overrides everything else:
  - zeroes `o_keys`, `o_count`, `o_index` and the buffer; returns to IDLE;
  - no pulses are generated;
  - a character presented in the same cycle is consumed and discarded.
- `o_keys` entries at index >= `o_count` are always zero.

## Timing
- Reset values:
  - state IDLE, buffer 0, length counter 0;
  - `o_keys` all zero, `o_count` 0, `o_index` 0;
  - `o_done`, `o_full_err`, `o_len_err` all 0;
  - `o_ready` 0 while `i_reset` is high, 1 from the first edge after release.
- Reset asserted mid-name drops the partial name. Reset asserted in COMMIT suppresses the write and the pulse.
- Latency: the pulse and the updated `o_keys`/`o_count`/`o_index` are visible in the cycle after the edge that accepted the `i_last` character. `o_ready` is low for that same cycle.
- Throughput: one name of N characters every N+1 cycles.
- All outputs are registered. `o_ready` is decoded from the state register only; it does not depend on `i_valid`.
- `o_keys` changes only in COMMIT or on clear. This keeps the lookup's inputs stable between its updates.

## Structure
- Package `dict_pkg`: the `dict_state_t` enum (IDLE, COLLECT, DISCARD, COMMIT) and the default key-geometry constants, shared with `find_index` instantiations.
- One sub-module, `key_assembler`: character buffer, length counter, overflow flag and clear. `dict_writer` keeps the FSM, the table, count and pulses.

## Test plan
- ENTRIES=4, KEY_LENGTH=3: stream "DUP" (0x44,0x55,0x50 with last on 0x50) -> `o_done` one cycle later, `o_index`=0, `o_count`=1, `o_keys[0]`={0x44,0x55,0x50}.
- Stream "+" (single character with `i_last`) -> `o_keys[1]`={0x2B,0,0}, `o_count`=2, `o_ready` low exactly one cycle.
- Stream the 5-character name "SWAPX" -> `o_len_err` pulse after the last character, `o_count` unchanged, all characters accepted.
- Fill 4 entries, then send "A" -> `o_full_err` pulse, `o_keys` unchanged, `o_count`=4.
- Assert `i_clear` after 2 characters of a name -> `o_count`=0, all `o_keys` zero, no pulses. The next name writes to index 0.
- Assert `i_reset` in COMMIT -> no `o_done`, all outputs at their reset values. A random valid-gap stream feeding `find_index` finds every committed name at its recorded index.
